// File: rtl/token_packet_tx_pkg.sv
// Shared USB link-layer definitions: PID codes, CRC5 constants and the token TX FSM encoding.
package token_packet_tx_pkg;

  // Token PIDs
  localparam logic [3:0] PidOut   = 4'b0001;
  localparam logic [3:0] PidIn    = 4'b1001;
  localparam logic [3:0] PidSetup = 4'b1101;
  localparam logic [3:0] PidSof   = 4'b0101;
  // Data and handshake PIDs
  localparam logic [3:0] PidData0 = 4'b0011;
  localparam logic [3:0] PidData1 = 4'b1011;
  localparam logic [3:0] PidAck   = 4'b0010;
  localparam logic [3:0] PidNak   = 4'b1010;
  localparam logic [3:0] PidStall = 4'b1110;

  // CRC5: x^5 + x^2 + 1, remainder seeded with all ones
  localparam logic [4:0] Crc5Poly = 5'b00101;
  localparam logic [4:0] Crc5Init = 5'b11111;

  // Token payload is {endp, addr}: 11 bits, counter runs 0..10
  localparam logic [3:0] TokenLastBit = 4'd10;

  typedef enum logic [2:0] {
    StIdle,
    StCalc,
    StPid,
    StB1,
    StB2
  } tx_state_e;

  // One serial CRC5 step, data bit enters at the top of the register.
  function automatic logic [4:0] crc5_step(input logic [4:0] rem, input logic data_bit);
    logic fb;
    fb = rem[4] ^ data_bit;
    return {rem[3:0], 1'b0} ^ (fb ? Crc5Poly : 5'b00000);
  endfunction

  // On-wire CRC field: remainder inverted and bit-reversed (rem[4] sent first).
  function automatic logic [4:0] crc5_field(input logic [4:0] rem);
    logic [4:0] field;
    for (int i = 0; i < 5; i++) begin
      field[i] = ~rem[4-i];
    end
    return field;
  endfunction

endpackage

// File: rtl/crc5_serial.sv
// Bit-serial CRC5 remainder register, shared by the token transmitter and receive-side checker.
module crc5_serial
  import token_packet_tx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       init,
  input  logic       shift_en,
  input  logic       data_bit,
  output logic [4:0] rem
);

  logic [4:0] rem_q, rem_d;

  // Next remainder: init has priority over a shift
  always_comb begin
    rem_d = rem_q;
    if (init) begin
      rem_d = Crc5Init;
    end else if (shift_en) begin
      rem_d = crc5_step(rem_q, data_bit);
    end
  end

  // Remainder register
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= 5'b00000;
    end else begin
      rem_q <= rem_d;
    end
  end

  assign rem = rem_q;

endmodule

// File: rtl/token_packet_tx.sv
// Host-side USB token packet transmitter: computes CRC5 serially, then streams PID, ADDR/ENDP
// and ENDP/CRC5 bytes to the PHY over a valid/ready handshake.
module token_packet_tx
  import token_packet_tx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_req,
  input  logic [3:0] tx_pid,
  input  logic [6:0] tx_addr,
  input  logic [3:0] tx_endp,
  input  logic       crc5_en,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       tx_sop,
  output logic       tx_eop,
  output logic       tx_lp_sop_en,
  output logic       tx_lp_eop_en,
  output logic       tx_busy,
  output logic       tx_rej
);

  tx_state_e  state_q, state_d;
  logic [3:0] pid_q, pid_d;
  logic [6:0] addr_q, addr_d;
  logic [3:0] endp_q, endp_d;
  logic [3:0] cnt_q, cnt_d;

  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       sop_q, sop_d;
  logic       eop_q, eop_d;
  logic       lp_sop_q, lp_sop_d;
  logic       lp_eop_q, lp_eop_d;
  logic       busy_q, busy_d;
  logic       rej_q, rej_d;

  logic        crc_init;
  logic        crc_shift;
  logic        crc_bit;
  logic [4:0]  crc_rem;
  logic [10:0] token_bits;
  logic        accept;

  assign token_bits = {endp_q, addr_q};
  assign accept     = valid_q & tx_ready;
  assign crc_bit    = token_bits[cnt_q];

  crc5_serial u_crc5 (
    .clk      (clk),
    .rst      (rst),
    .init     (crc_init),
    .shift_en (crc_shift),
    .data_bit (crc_bit),
    .rem      (crc_rem)
  );

  // Next-state logic, field latching and registered-output next values
  always_comb begin
    state_d   = state_q;
    pid_d     = pid_q;
    addr_d    = addr_q;
    endp_d    = endp_q;
    cnt_d     = cnt_q;
    crc_init  = 1'b0;
    crc_shift = 1'b0;
    lp_sop_d  = 1'b0;
    lp_eop_d  = 1'b0;
    rej_d     = 1'b0;

    case (state_q)
      StIdle: begin
        if (tx_req) begin
          if (crc5_en) begin
            pid_d    = tx_pid;
            addr_d   = tx_addr;
            endp_d   = tx_endp;
            cnt_d    = 4'd0;
            crc_init = 1'b1;
            state_d  = StCalc;
          end else begin
            rej_d = 1'b1;
          end
        end
      end
      StCalc: begin
        crc_shift = 1'b1;
        cnt_d     = cnt_q + 4'd1;
        if (cnt_q == TokenLastBit) begin
          state_d = StPid;
        end
      end
      StPid: begin
        if (accept) begin
          lp_sop_d = 1'b1;
          state_d  = StB1;
        end
      end
      StB1: begin
        if (accept) begin
          state_d = StB2;
        end
      end
      StB2: begin
        if (accept) begin
          lp_eop_d = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs follow the next state so they line up with the state register
    valid_d = (state_d == StPid) || (state_d == StB1) || (state_d == StB2);
    sop_d   = (state_d == StPid);
    eop_d   = (state_d == StB2);
    busy_d  = (state_d != StIdle);
    case (state_d)
      StPid:   data_d = {~pid_d, pid_d};
      StB1:    data_d = {endp_d[0], addr_d};
      StB2:    data_d = {crc5_field(crc_rem), endp_d[3:1]};
      default: data_d = 8'h00;
    endcase
  end

  // State, latched fields and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      pid_q    <= 4'd0;
      addr_q   <= 7'd0;
      endp_q   <= 4'd0;
      cnt_q    <= 4'd0;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
      lp_sop_q <= 1'b0;
      lp_eop_q <= 1'b0;
      busy_q   <= 1'b0;
      rej_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pid_q    <= pid_d;
      addr_q   <= addr_d;
      endp_q   <= endp_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      sop_q    <= sop_d;
      eop_q    <= eop_d;
      lp_sop_q <= lp_sop_d;
      lp_eop_q <= lp_eop_d;
      busy_q   <= busy_d;
      rej_q    <= rej_d;
    end
  end

  assign tx_data      = data_q;
  assign tx_valid     = valid_q;
  assign tx_sop       = sop_q;
  assign tx_eop       = eop_q;
  assign tx_lp_sop_en = lp_sop_q;
  assign tx_lp_eop_en = lp_eop_q;
  assign tx_busy      = busy_q;
  assign tx_rej       = rej_q;

endmodule

// File: tb/tb_token_packet_tx.sv
// Directed self-checking bench for token_packet_tx.
module tb_token_packet_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_req;
  logic [3:0] tx_pid;
  logic [6:0] tx_addr;
  logic [3:0] tx_endp;
  logic       crc5_en;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_sop;
  logic       tx_eop;
  logic       tx_lp_sop_en;
  logic       tx_lp_eop_en;
  logic       tx_busy;
  logic       tx_rej;

  int checks = 0;
  int errors = 0;

  token_packet_tx dut (
    .clk          (clk),
    .rst          (rst),
    .tx_req       (tx_req),
    .tx_pid       (tx_pid),
    .tx_addr      (tx_addr),
    .tx_endp      (tx_endp),
    .crc5_en      (crc5_en),
    .tx_ready     (tx_ready),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_sop       (tx_sop),
    .tx_eop       (tx_eop),
    .tx_lp_sop_en (tx_lp_sop_en),
    .tx_lp_eop_en (tx_lp_eop_en),
    .tx_busy      (tx_busy),
    .tx_rej       (tx_rej)
  );

  always #5 clk = ~clk;

  // Golden serial CRC5 over {endp, addr}, addr[0] first
  function automatic logic [4:0] golden_crc5(input logic [6:0] a, input logic [3:0] e);
    logic [10:0] d;
    logic [4:0]  r;
    logic        fb;
    d = {e, a};
    r = 5'b11111;
    for (int i = 0; i < 11; i++) begin
      fb = r[4] ^ d[i];
      r  = {r[3:0], 1'b0};
      if (fb) r = r ^ 5'b00101;
    end
    return r;
  endfunction

  function automatic logic [7:0] exp_b2(input logic [6:0] a, input logic [3:0] e);
    logic [4:0] r;
    logic [7:0] b;
    r = golden_crc5(a, e);
    b[2:0] = e[3:1];
    for (int i = 0; i < 5; i++) b[3+i] = ~r[4-i];
    return b;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one-cycle request; returns one cycle later with tx_req low
  task automatic request(input logic [3:0] p, input logic [6:0] a, input logic [3:0] e);
    tx_pid  = p;
    tx_addr = a;
    tx_endp = e;
    tx_req  = 1'b1;
    tick(1);
    tx_req  = 1'b0;
  endtask

  // Consume three bytes, stalling each for 'stall' cycles; ends one cycle after byte2 accepted
  task automatic recv_packet(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input int stall);
    logic [7:0] exp_d;
    int         n;
    for (int i = 0; i < 3; i++) begin
      exp_d = (i == 0) ? b0 : (i == 1) ? b1 : b2;
      tx_ready = (stall == 0);
      n = 0;
      while (tx_valid !== 1'b1 && n < 40) begin
        tick(1);
        n++;
      end
      chk({tag, " valid"}, {7'd0, tx_valid}, 8'd1);
      chk({tag, " data"}, tx_data, exp_d);
      chk({tag, " sop"}, {7'd0, tx_sop}, {7'd0, (i == 0)});
      chk({tag, " eop"}, {7'd0, tx_eop}, {7'd0, (i == 2)});
      for (int s = 0; s < stall; s++) begin
        tick(1);
        chk({tag, " hold data"}, tx_data, exp_d);
        chk({tag, " hold flags"}, {5'd0, tx_valid, tx_sop, tx_eop},
            {5'd0, 1'b1, (i == 0), (i == 2)});
        chk({tag, " hold lp_eop"}, {7'd0, tx_lp_eop_en}, 8'd0);
      end
      tx_ready = 1'b1;
      tick(1);
      if (i == 0) chk({tag, " lp_sop"}, {7'd0, tx_lp_sop_en}, 8'd1);
    end
    chk({tag, " lp_eop"}, {7'd0, tx_lp_eop_en}, 8'd1);
    chk({tag, " busy fall"}, {7'd0, tx_busy}, 8'd0);
    chk({tag, " valid fall"}, {7'd0, tx_valid}, 8'd0);
    tx_ready = 1'b1;
  endtask

  initial begin
    rst      = 1'b1;
    tx_req   = 1'b0;
    tx_pid   = 4'd0;
    tx_addr  = 7'd0;
    tx_endp  = 4'd0;
    crc5_en  = 1'b1;
    tx_ready = 1'b1;
    tick(3);

    // Reset state
    chk("reset data", tx_data, 8'h00);
    chk("reset flags", {2'd0, tx_valid, tx_sop, tx_eop, tx_lp_sop_en, tx_lp_eop_en, tx_busy},
        8'h00);
    chk("reset rej", {7'd0, tx_rej}, 8'd0);
    rst = 1'b0;
    tick(1);

    // SETUP addr 0 endp 0, ready high: 2D 00 10, byte0 12 cycles after request
    request(4'b1101, 7'h00, 4'h0);
    chk("setup busy", {7'd0, tx_busy}, 8'd1);
    tick(10);
    chk("setup latency early", {7'd0, tx_valid}, 8'd0);
    tick(1);
    chk("setup latency", {7'd0, tx_valid}, 8'd1);
    recv_packet("setup", 8'h2D, 8'h00, 8'h10, 0);
    tick(1);
    chk("setup lp_eop single", {7'd0, tx_lp_eop_en}, 8'd0);

    // IN addr 7F endp F
    request(4'b1001, 7'h7F, 4'hF);
    recv_packet("in", 8'h69, 8'hFF, exp_b2(7'h7F, 4'hF), 0);

    // OUT with 5-cycle backpressure per byte
    request(4'b0001, 7'h3A, 4'h5);
    recv_packet("bp", 8'hE1, 8'hBA, exp_b2(7'h3A, 4'h5), 5);

    // Rejected request with crc5_en low
    crc5_en = 1'b0;
    request(4'b1001, 7'h11, 4'h1);
    chk("rej pulse", {7'd0, tx_rej}, 8'd1);
    chk("rej busy", {7'd0, tx_busy}, 8'd0);
    crc5_en = 1'b1;
    tick(1);
    chk("rej single", {7'd0, tx_rej}, 8'd0);
    tick(12);
    chk("rej no valid", {6'd0, tx_valid, tx_busy}, 8'd0);

    // Request during B1 ignored, then back-to-back request in lp_eop cycle
    request(4'b0101, 7'h15, 4'h2);
    tick(11);
    chk("b2b p1 b0", tx_data, 8'hA5);
    tick(1);
    chk("b2b p1 b1", tx_data, 8'h15);
    request(4'b0001, 7'h44, 4'h7);
    chk("b2b ignored rej", {7'd0, tx_rej}, 8'd0);
    chk("b2b p1 b2", tx_data, exp_b2(7'h15, 4'h2));
    tick(1);
    chk("b2b p1 lp_eop", {7'd0, tx_lp_eop_en}, 8'd1);
    request(4'b1001, 7'h01, 4'h1);
    chk("b2b p2 busy", {7'd0, tx_busy}, 8'd1);
    tick(10);
    chk("b2b p2 early", {7'd0, tx_valid}, 8'd0);
    tick(1);
    chk("b2b p2 latency", {7'd0, tx_valid}, 8'd1);
    recv_packet("b2b p2", 8'h69, 8'h81, exp_b2(7'h01, 4'h1), 0);

    // Reset during B1, then a clean packet
    request(4'b1101, 7'h05, 4'h3);
    tick(12);
    chk("rst pre b1", tx_data, 8'h85);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("rst data", tx_data, 8'h00);
    chk("rst flags", {1'b0, tx_rej, tx_valid, tx_sop, tx_eop, tx_lp_sop_en, tx_lp_eop_en,
        tx_busy}, 8'h00);
    tick(1);
    chk("rst no lp_eop", {6'd0, tx_lp_eop_en, tx_valid}, 8'd0);
    request(4'b1101, 7'h05, 4'h3);
    tick(11);
    chk("post rst latency", {7'd0, tx_valid}, 8'd1);
    recv_packet("post rst", 8'h2D, 8'h85, exp_b2(7'h05, 4'h3), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
